f_fetch_unit: RTL and testbench
===============================

// Module: f_fetch_unit
// PURPOSE
//  Fetch stage of the MIPS pipeline; drives the F/D pipeline register.
//  - Owns the PC register and computes next-PC: sequential, or a redirect target from D.
//  - Drives the instruction-memory address and forwards the fetched word.
//  - Produces F_instr, F_pc and F_pc8 for the F/D register; honours the same stall signal.
//  - Latches a redirect that arrives during a stall.
//  - Keeps a retired-fetch counter for the bench and debug.
// PARAMETERS
//  PC_RESET   32'h0000_3000  PC value after reset
//  IM_BASE    32'h0000_3000  lowest legal fetch address
//  IM_LIMIT   32'h0000_6FFF  highest legal fetch address (inclusive)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   synchronous, active-high
//  stall         in   1   hazard stall; same signal that holds the F/D register
//  D_redirect    in   1   branch taken, or j/jal/jr, resolved in D this cycle
//  D_target      in   32  redirect target PC
//  i_inst_addr   out  32  instruction memory address (= F_pc)
//  i_inst_rdata  in   32  instruction memory read data, combinational
//  F_pc          out  32  PC of the instruction in F
//  F_pc8         out  32  F_pc + 8 (link address)
//  F_instr       out  32  fetched instruction to the F/D register
//  F_exc_code    out  5   fetch exception code; 5'd0 = none
//  fetch_cnt     out  32  count of cycles in which F advanced
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//  - pc <= PC_RESET; pend_vld <= 0; pend_tgt <= 0; fetch_cnt <= 0.
//  - Outputs after reset: F_pc = 0x3000, F_pc8 = 0x3008, F_exc_code = 0, fetch_cnt = 0.
//  - reset overrides stall and D_redirect in the same cycle.
//  Combinational outputs:
//  - F_pc = i_inst_addr = pc.
//  - F_pc8 = pc + 32'd8, modulo 2^32.
//  - F_instr = i_inst_rdata, except where the exception rule below zeroes it.
//  Delay slot: a branch in D means F already holds the delay slot.
//  - The redirect replaces the next PC, not the current one.
//  - The delay slot is never squashed.
//  Next-PC state machine:
//  - IDLE (pend_vld=0), stall=0:
//    - D_redirect=1: pc <= D_target.
//    - D_redirect=0: pc <= pc + 4.
//  - IDLE, stall=1:
//    - pc holds.
//    - If D_redirect=1: pend_tgt <= D_target, pend_vld <= 1, go to PEND.
//  - PEND (pend_vld=1), stall=1:
//    - pc holds.
//    - A new D_redirect=1 overwrites pend_tgt (newest wins).
//  - PEND, stall=0:
//    - pc <= D_redirect ? D_target : pend_tgt; pend_vld <= 0; go to IDLE.
//    - A live redirect takes priority over the pending one.
//  - PC arithmetic wraps modulo 2^32; no saturation.
//  fetch_cnt:
//  - +1 on every non-stalled, non-reset edge.
//  - Wraps from 0xFFFF_FFFF to 0.
// CONFIGURATION
//  Macro F_FETCH_EXC_EN.
//  - Defined:
//    - If pc[1:0] != 0, or pc < IM_BASE, or pc > IM_LIMIT: F_exc_code = 5'd4 (AdEL) and F_instr = 32'h0 (nop).
//    - Both are combinational on pc; pc update rules are unchanged.
//  - Undefined:
//    - F_exc_code is tied to 5'd0.
//    - F_instr = i_inst_rdata unconditionally.
// TESTING
//  T1 reset, 3 free cycles, no stall: F_pc = 0x3000, 0x3004, 0x3008, 0x300C; F_pc8 = 0x3008 ... 0x3014; fetch_cnt = 3.
//  T2 at F_pc=0x3010, D_redirect=1, D_target=0x3100: next F_pc = 0x3100 (0x3010 itself is the delay slot).
//  T3 stall=1 at 0x3020 with D_redirect=1, D_target=0x3200, stall held 2 more cycles: F_pc stays 0x3020; after release F_pc = 0x3200.
//  T4 PEND with pend_tgt=0x3200; on the release cycle D_redirect=1, D_target=0x3300: F_pc = 0x3300; pend_vld cleared.
//  T5 stall and reset both high mid-operation: F_pc = 0x3000, pend_vld = 0, fetch_cnt = 0.
//  T6 F_FETCH_EXC_EN defined, D_target=0x3002, then 0x7000: F_exc_code = 4 and F_instr = 0 for each; without the macro, F_exc_code = 0 and F_instr = i_inst_rdata.

Source files
------------

// File: rtl/f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : f_fetch_unit
//  Description : Fetch stage of the MIPS pipeline. Owns the PC register,
//                selects the next PC (sequential or a redirect from D),
//                drives the instruction-memory address and presents the
//                fetched word, PC and link address to the F/D register.
//                A redirect that arrives while the pipe is stalled is held
//                and applied on the first non-stalled edge.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    F_FETCH_EXC_EN  - when defined, misaligned or out-of-window fetch
//                      addresses raise AdEL (code 4) and the fetched word is
//                      replaced by a nop. When undefined, no fetch exceptions.
// ----------------------------------------------------------------------------
//  Ports:
//    clk           in   1   clock, rising edge
//    reset         in   1   synchronous, active-high
//    stall         in   1   hazard stall (same signal holding the F/D reg)
//    D_redirect    in   1   taken branch / j / jal / jr resolved in D
//    D_target      in   32  redirect target PC
//    i_inst_addr   out  32  instruction memory address (= F_pc)
//    i_inst_rdata  in   32  instruction memory read data (combinational)
//    F_pc          out  32  PC of the instruction in F
//    F_pc8         out  32  F_pc + 8 (link address)
//    F_instr       out  32  fetched instruction to the F/D register
//    F_exc_code    out  5   fetch exception code, 0 = none
//    fetch_cnt     out  32  count of cycles in which F advanced
// ============================================================================
module f_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_pc8,
    output logic [31:0] F_instr,
    output logic [4:0]  F_exc_code,
    output logic [31:0] fetch_cnt
);

    localparam logic [4:0] EXC_NONE = 5'd0;

    // ST_PEND means a redirect was seen during a stall and is still owed.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            pend_tgt_q  <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_tgt_q  <= pend_tgt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection. A redirect from D targets the instruction after
    // the delay slot, which is already in F, so it replaces the next PC
    // and never the current one.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        fetch_cnt_d = stall ? fetch_cnt_q : fetch_cnt_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (!stall) begin
                    pc_d = D_redirect ? D_target : pc_q + 32'd4;
                end else if (D_redirect) begin
                    pend_tgt_d = D_target;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    // Newest redirect wins while still stalled.
                    if (D_redirect) begin
                        pend_tgt_d = D_target;
                    end
                end else begin
                    // A live redirect is younger than the held one.
                    pc_d    = D_redirect ? D_target : pend_tgt_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i_inst_addr = pc_q;
    assign F_pc        = pc_q;
    assign F_pc8       = pc_q + 32'd8;
    assign fetch_cnt   = fetch_cnt_q;

`ifdef F_FETCH_EXC_EN
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic w_addr_bad;
    assign w_addr_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
    assign F_exc_code = w_addr_bad ? EXC_ADEL : EXC_NONE;
    assign F_instr    = w_addr_bad ? 32'h0 : i_inst_rdata;
`else
    // Address window only matters when fetch exceptions are enabled.
    logic w_unused_params;
    assign w_unused_params = ^{IM_BASE, IM_LIMIT};
    assign F_exc_code      = EXC_NONE;
    assign F_instr         = i_inst_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f_fetch_unit
//  Description : Self-checking bench for f_fetch_unit. A behavioural model
//                (PC plus a queue of owed redirects) predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_f_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT = 32'h0000_6FFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        D_redirect;
    logic [31:0] D_target;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_pc;
    logic [31:0] F_pc8;
    logic [31:0] F_instr;
    logic [4:0]  F_exc_code;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_pend[$];

    f_fetch_unit #(
        .PC_RESET (PC_RESET),
        .IM_BASE  (IM_BASE),
        .IM_LIMIT (IM_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .D_redirect   (D_redirect),
        .D_target     (D_target),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .F_pc         (F_pc),
        .F_pc8        (F_pc8),
        .F_instr      (F_instr),
        .F_exc_code   (F_exc_code),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < IM_BASE) || (a > IM_LIMIT);
    endfunction

    function automatic logic [4:0] exp_exc(input logic [31:0] a);
`ifdef F_FETCH_EXC_EN
        return addr_bad(a) ? 5'd4 : 5'd0;
`else
        return (a == 32'h0) ? 5'd0 : 5'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
`ifdef F_FETCH_EXC_EN
        return addr_bad(a) ? 32'h0 : mem_word(a);
`else
        return mem_word(a);
`endif
    endfunction

    // Drive one cycle of inputs, advance the model across the edge,
    // then settle 1 time unit past the edge for sampling.
    task automatic cycle(input logic rst, input logic s, input logic r, input logic [31:0] t);
        reset      = rst;
        stall      = s;
        D_redirect = r;
        D_target   = t;
        @(posedge clk);
        if (rst) begin
            m_pc  = PC_RESET;
            m_cnt = 32'd0;
            m_pend.delete();
        end else if (s) begin
            if (r) begin
                m_pend.delete();
                m_pend.push_back(t);
            end
        end else begin
            if (r)                    m_pc = t;
            else if (m_pend.size() > 0) m_pc = m_pend[0];
            else                      m_pc = m_pc + 32'd4;
            m_pend.delete();
            m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_3400);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_3400);
        checks++; if (F_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", F_pc, 32'h0000_3000); end
        checks++; if (F_pc8 !== 32'h0000_3008) begin errors++; $display("FAIL reset_pc8: got %h expected %h", F_pc8, 32'h0000_3008); end
        checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fetch_cnt); end
        checks++; if (F_exc_code !== 5'd0) begin errors++; $display("FAIL reset_exc: got %0d expected 0", F_exc_code); end
        checks++; if (i_inst_addr !== 32'h0000_3000) begin errors++; $display("FAIL reset_addr: got %h expected %h", i_inst_addr, 32'h0000_3000); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            exp_pc = 32'h0000_3000 + 32'(4 * i);
            checks++; if (F_pc !== exp_pc) begin errors++; $display("FAIL seq_pc: got %h expected %h", F_pc, exp_pc); end
            checks++; if (F_pc8 !== exp_pc + 32'd8) begin errors++; $display("FAIL seq_pc8: got %h expected %h", F_pc8, exp_pc + 32'd8); end
            checks++; if (F_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_instr: got %h expected %h", F_instr, mem_word(exp_pc)); end
        end
        checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt: got %0d expected 3", fetch_cnt); end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3010) begin errors++; $display("FAIL redir_pre_pc: got %h expected %h", F_pc, 32'h0000_3010); end
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3100);
        checks++; if (F_pc !== 32'h0000_3100) begin errors++; $display("FAIL redir_pc: got %h expected %h", F_pc, 32'h0000_3100); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3104) begin errors++; $display("FAIL redir_next_pc: got %h expected %h", F_pc, 32'h0000_3104); end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] cnt0;
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3020);
        cnt0 = fetch_cnt;
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_3200);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3020) begin errors++; $display("FAIL stall_hold_pc: got %h expected %h", F_pc, 32'h0000_3020); end
        checks++; if (fetch_cnt !== cnt0) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", fetch_cnt, cnt0); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3200) begin errors++; $display("FAIL stall_release_pc: got %h expected %h", F_pc, 32'h0000_3200); end
        checks++; if (fetch_cnt !== cnt0 + 32'd1) begin errors++; $display("FAIL release_cnt: got %0d expected %0d", fetch_cnt, cnt0 + 32'd1); end
    endtask

    task automatic test_live_priority();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_3200);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3300);
        checks++; if (F_pc !== 32'h0000_3300) begin errors++; $display("FAIL live_pc: got %h expected %h", F_pc, 32'h0000_3300); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3304) begin errors++; $display("FAIL live_cleared_pc: got %h expected %h", F_pc, 32'h0000_3304); end
    endtask

    task automatic test_newest_wins();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_3400);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_3500);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3500) begin errors++; $display("FAIL newest_pc: got %h expected %h", F_pc, 32'h0000_3500); end
    endtask

    task automatic test_stall_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_3600);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_3700);
        checks++; if (F_pc !== 32'h0000_3000) begin errors++; $display("FAIL sr_pc: got %h expected %h", F_pc, 32'h0000_3000); end
        checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL sr_cnt: got %0d expected 0", fetch_cnt); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_3004) begin errors++; $display("FAIL sr_nopend_pc: got %h expected %h", F_pc, 32'h0000_3004); end
    endtask

    task automatic test_exception();
        logic [31:0] tgts[5];
        tgts = '{32'h0000_3002, 32'h0000_7000, 32'h0000_6FFC, 32'h0000_2FFC, 32'h0000_3000};
        foreach (tgts[i]) begin
            cycle(1'b0, 1'b0, 1'b1, tgts[i]);
            checks++; if (F_pc !== tgts[i]) begin errors++; $display("FAIL exc_pc: got %h expected %h", F_pc, tgts[i]); end
            checks++; if (F_exc_code !== exp_exc(tgts[i])) begin errors++; $display("FAIL exc_code @%h: got %0d expected %0d", tgts[i], F_exc_code, exp_exc(tgts[i])); end
            checks++; if (F_instr !== exp_instr(tgts[i])) begin errors++; $display("FAIL exc_instr @%h: got %h expected %h", tgts[i], F_instr, exp_instr(tgts[i])); end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checks++; if (F_pc8 !== 32'h0000_0004) begin errors++; $display("FAIL wrap_pc8: got %h expected %h", F_pc8, 32'h0000_0004); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (F_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h expected %h", F_pc, 32'h0000_0000); end
    endtask

    task automatic test_random();
        logic        s, r, rs;
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 99) < 35);
            r  = ($urandom_range(0, 99) < 30);
            rs = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) t = $urandom();
            else                           t = 32'h0000_3000 + ($urandom_range(0, 32'h0FFF) << 2);
            cycle(rs, s, r, t);
            checks++; if (F_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d: got %h expected %h", i, F_pc, m_pc); end
            checks++; if (F_pc8 !== m_pc + 32'd8) begin errors++; $display("FAIL rnd_pc8 cyc %0d: got %h expected %h", i, F_pc8, m_pc + 32'd8); end
            checks++; if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", i, fetch_cnt, m_cnt); end
            checks++; if (F_instr !== exp_instr(m_pc)) begin errors++; $display("FAIL rnd_instr cyc %0d: got %h expected %h", i, F_instr, exp_instr(m_pc)); end
            checks++; if (F_exc_code !== exp_exc(m_pc)) begin errors++; $display("FAIL rnd_exc cyc %0d: got %0d expected %0d", i, F_exc_code, exp_exc(m_pc)); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        D_redirect = 1'b0;
        D_target   = 32'h0;
        m_pc       = PC_RESET;
        m_cnt      = 32'd0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_redirect();
        test_live_priority();
        test_newest_wins();
        test_stall_reset();
        test_exception();
        test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
